// File: rtl/series_eval_seq.sv
// rtl/series_eval_seq.sv - sequential fixed-point series evaluator, one term per cycle
module series_eval_seq #(
    parameter int XW      = 8,
    parameter int CW      = 16,
    parameter int ACC_W   = 32,
    parameter int MAX_DEG = 7,
    parameter int NW      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XW-1:0]         x_in,
    input  logic [NW-1:0]         n_in,
    input  logic                  mode,
    input  logic [MAX_DEG*CW-1:0] coeff_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      result,
    output logic                  overflow,
    output logic                  error
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [NW-1:0]           MAX_N   = NW'(MAX_DEG);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state;
    logic [XW-1:0]           x_r;
    logic [XW-1:0]           p;
    logic [NW-1:0]           n_r;
    logic [NW-1:0]           k;
    logic                    mode_r;
    logic                    ovf_run;
    logic signed [ACC_W-1:0] acc;

    logic [CW-1:0]           c_k;
    logic [XW:0]             term;
    logic [XW-1:0]           p_next;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   term_ext;
    logic signed [ACC_W:0]   sum;
    logic                    sat;
    logic signed [ACC_W-1:0] acc_next;
    logic                    add_term;
    logic                    bad_n;

    always_comb begin
        c_k = '0;
        for (int i = 1; i <= MAX_DEG; i++) begin
            if (k == NW'(i)) begin
                c_k = coeff_flat[(i-1)*CW +: CW];
            end
        end
    end

    // Products are formed at full width before the shift so no bits are lost early.
    assign term     = (XW+1)'(({{CW{1'b0}}, p} * {{XW{1'b0}}, c_k}) >> (CW-1));
    assign p_next   = XW'(({{XW{1'b0}}, p} * {{XW{1'b0}}, x_r}) >> XW);

    assign add_term = mode_r | k[0];
    assign acc_ext  = {acc[ACC_W-1], acc};
    assign term_ext = {{(ACC_W-XW){1'b0}}, term};
    assign sum      = add_term ? (acc_ext + term_ext) : (acc_ext - term_ext);
    assign sat      = sum[ACC_W] != sum[ACC_W-1];
    assign acc_next = sat ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

    assign bad_n    = (n_in == '0) || (n_in > MAX_N);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            error     <= 1'b0;
            x_r       <= '0;
            p         <= '0;
            n_r       <= '0;
            k         <= '0;
            mode_r    <= 1'b0;
            ovf_run   <= 1'b0;
            acc       <= '0;
        end else begin
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (bad_n) begin
                            error <= 1'b1;
                        end else begin
                            x_r      <= x_in;
                            p        <= x_in;
                            n_r      <= n_in;
                            mode_r   <= mode;
                            k        <= NW'(1);
                            acc      <= '0;
                            ovf_run  <= 1'b0;
                            overflow <= 1'b0;
                            in_ready <= 1'b0;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    p       <= p_next;
                    k       <= k + 1'b1;
                    ovf_run <= ovf_run | sat;
                    if (k == n_r) begin
                        result    <= acc_next;
                        overflow  <= ovf_run | sat;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_series_eval_seq.sv
// tb/tb_series_eval_seq.sv - scoreboard bench for series_eval_seq
module tb_series_eval_seq;

    localparam int XW      = 8;
    localparam int CW      = 16;
    localparam int ACC_W   = 10;
    localparam int MAX_DEG = 7;
    localparam int NW      = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [XW-1:0]         x_in;
    logic [NW-1:0]         n_in;
    logic                  mode;
    logic [MAX_DEG*CW-1:0] coeff_flat;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_W-1:0]      result;
    logic                  overflow;
    logic                  error;

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    series_eval_seq #(
        .XW(XW), .CW(CW), .ACC_W(ACC_W), .MAX_DEG(MAX_DEG), .NW(NW)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .n_in(n_in), .mode(mode), .coeff_flat(coeff_flat),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_result: got 0x%0h with no job outstanding", result);
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("overflow", 32'(overflow), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [MAX_DEG*CW-1:0] pack(input logic [CW-1:0] c1, c2, c3, c4, c5, c6, c7);
        return {c7, c6, c5, c4, c3, c2, c1};
    endfunction

    // Called just after a rising edge with the DUT idle; returns just after a rising edge.
    task automatic run_job(input logic [XW-1:0] x, input int n, input logic m,
                           input logic [ACC_W-1:0] exp_res, input logic exp_ovf, input int hold);
        int   cyc;
        exp_t e;
        e.res = exp_res;
        e.ovf = exp_ovf;
        sb.push_back(e);
        out_ready = (hold == 0);
        x_in      = x;
        n_in      = NW'(n);
        mode      = m;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_accept", 32'(in_ready), 0);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("latency", 32'(cyc), 32'(n));
        chk("in_ready_in_done", 32'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i < 3);
            n_in     = NW'(1);
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_result", 32'(result), 32'(exp_res));
            chk("hold_no_error", 32'(error), 0);
        end
        if (hold > 0) begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("out_valid_after_hs", 32'(out_valid), 0);
        chk("in_ready_after_hs", 32'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    localparam logic [MAX_DEG*CW-1:0] BASE_C =
        {16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h2AAA, 16'h4000, 16'h8000};

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        x_in       = '0;
        n_in       = '0;
        mode       = 1'b0;
        coeff_flat = BASE_C;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_error", 32'(error), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        run_job(8'h80, 1, 1'b0, 10'h080, 1'b0, 0);
        run_job(8'h80, 2, 1'b0, 10'h060, 1'b0, 0);
        run_job(8'h80, 2, 1'b1, 10'h0A0, 1'b0, 0);
        run_job(8'h80, 3, 1'b0, 10'h06A, 1'b0, 5);

        coeff_flat = pack(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        run_job(8'hFF, 7, 1'b1, 10'h1FF, 1'b1, 0);
        run_job(8'h80, 1, 1'b0, 10'h080, 1'b0, 0);

        // Alternating signs driven below the negative limit: -507 then -503.
        coeff_flat = pack(16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        run_job(8'hFF, 4, 1'b0, 10'h200, 1'b1, 0);

        coeff_flat = BASE_C;
        n_in     = NW'(0);
        in_valid = 1'b1;
        @(posedge clk);
        #1 n_in = NW'(8);
        @(negedge clk);
        chk("err_n0_pulse", 32'(error), 1);
        chk("err_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("err_n8_pulse", 32'(error), 1);
        chk("err_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("err_cleared", 32'(error), 0);
        chk("err_in_ready_after", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        x_in     = 8'h80;
        n_in     = NW'(5);
        mode     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        repeat (8) @(negedge clk);
        chk("abort_no_completion", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        run_job(8'h80, 1, 1'b0, 10'h080, 1'b0, 0);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
